// File: rtl/review2015_pkg.sv
// Shared types and constants for the review2015 serial timer protocol initiator.
package review2015_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_PRE,
        ST_DATA,
        ST_WAIT_DONE,
        ST_ACK
    } tx_state_t;

    localparam logic [3:0] PREAMBLE  = 4'b1101;
    localparam int         DATA_BITS = 4;
    localparam int         PRE_BITS  = 4;

    // Bit 'pos' of a 4-bit word counted from the MSB (pos 0 returns word[3]).
    function automatic logic msb_first_bit(input logic [3:0] word, input logic [2:0] pos);
        logic [1:0] sel;
        sel = 2'(3'd3 - pos);
        return word[sel];
    endfunction

endpackage

// File: rtl/review2015_tx_timeout.sv
// WAIT_DONE watchdog: loaded with TIMEOUT_CYCLES-1 on entry, counts down while
// running and flags expiry once it sits at zero. Only used with REVIEW2015_TX_TIMEOUT_EN.
module review2015_tx_timeout #(
    parameter int TIMEOUT_CYCLES = 17000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES - 1);
        end else if (run && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = run && (count == '0);

endmodule

// File: rtl/review2015_fsm_tx.sv
// Initiator for the review2015 serial timer protocol: gap, preamble 1101, 4-bit delay
// MSB first, then waits for done and acknowledges. REVIEW2015_TX_TIMEOUT_EN adds a WAIT_DONE timeout.
module review2015_fsm_tx
    import review2015_pkg::*;
#(
    parameter int GAP_CYCLES = 2
`ifdef REVIEW2015_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 17000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] delay,
    output logic       ready,
    output logic       busy,
    output logic       x,
    input  logic       done,
    output logic       ack,
    output logic       timeout
);

    localparam int                 GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [2:0]         PRE_LAST  = 3'(PRE_BITS - 1);
    localparam logic [2:0]         DATA_LAST = 3'(DATA_BITS - 1);

    tx_state_t        state;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       idx;
    logic [3:0]       data_q;

`ifdef REVIEW2015_TX_TIMEOUT_EN
    logic tmo_load;
    logic tmo_run;
    logic tmo_expired;
    logic timeout_pulse;

    assign tmo_load = (state == ST_DATA) && (idx == DATA_LAST);
    assign tmo_run  = (state == ST_WAIT_DONE);

    review2015_tx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tmo_load),
        .run    (tmo_run),
        .expired(tmo_expired)
    );

    assign timeout = timeout_pulse;
`else
    assign timeout = 1'b0;
`endif

    // Outputs are registered alongside the state so each reflects the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            idx     <= '0;
            data_q  <= '0;
            x       <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
`ifdef REVIEW2015_TX_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef REVIEW2015_TX_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_q  <= delay;
                        gap_cnt <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_PRE;
                            x     <= PREAMBLE[3];
                        end else begin
                            state <= ST_GAP;
                            x     <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_PRE;
                        x     <= PREAMBLE[3];
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                // The last preamble edge loads the first data bit so the receiver's shift window lines up.
                ST_PRE: begin
                    if (idx == PRE_LAST) begin
                        state <= ST_DATA;
                        idx   <= '0;
                        x     <= data_q[3];
                    end else begin
                        idx <= idx + 3'd1;
                        x   <= msb_first_bit(PREAMBLE, idx + 3'd1);
                    end
                end
                ST_DATA: begin
                    if (idx == DATA_LAST) begin
                        state <= ST_WAIT_DONE;
                        idx   <= '0;
                        x     <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                        x   <= msb_first_bit(data_q, idx + 3'd1);
                    end
                end
                // done takes priority over a timeout expiring on the same edge.
                ST_WAIT_DONE: begin
                    if (done) begin
                        state <= ST_ACK;
                        ack   <= 1'b1;
                    end
`ifdef REVIEW2015_TX_TIMEOUT_EN
                    else if (tmo_expired) begin
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        ready         <= 1'b1;
                        timeout_pulse <= 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    x     <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_review2015_fsm_tx.sv
// Self-checking bench for review2015_fsm_tx: randomized transfers against a frame model
// built from the protocol rules; REVIEW2015_TX_TIMEOUT_EN also exercises the timeout.
module tb_review2015_fsm_tx;

    localparam int GAP = 2;
    localparam int FL  = GAP + 8;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       done;
    logic [3:0] delay;
    logic       ready, busy, x, ack, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    review2015_fsm_tx #(
        .GAP_CYCLES(GAP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .delay  (delay),
        .ready  (ready),
        .busy   (busy),
        .x      (x),
        .done   (done),
        .ack    (ack),
        .timeout(timeout)
    );

`ifdef REVIEW2015_TX_TIMEOUT_EN
    logic t_ready, t_busy, t_x, t_ack, t_timeout;

    review2015_fsm_tx #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut_tmo (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .delay  (delay),
        .ready  (t_ready),
        .busy   (t_busy),
        .x      (t_x),
        .done   (done),
        .ack    (t_ack),
        .timeout(t_timeout)
    );
`endif

    // Expected line contents after acceptance: GAP zeros, preamble 1101, delay MSB first.
    function automatic logic frame_bit(input logic [3:0] d, input int i);
        logic [FL-1:0] f;
        f = FL'({4'b1101, d});
        return f[FL-1-i];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b1;
        done    = 1'b1;
        delay   = 4'($urandom);
        tick();
        tick();
        checks++; if ({busy, ready, ack, timeout} !== 4'b0100) begin errors++; $display("[TB] FAIL reset_status: got %b expected %b", {busy, ready, ack, timeout}, 4'b0100); end
        checks++; if (x !== 1'b0) begin errors++; $display("[TB] FAIL reset_x: got %b expected 0", x); end
        start   = 1'b0;
        done    = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++; if ({busy, ready, ack, timeout, x} !== 5'b01000) begin errors++; $display("[TB] FAIL post_reset_idle: got %b expected %b", {busy, ready, ack, timeout, x}, 5'b01000); end
    endtask

    task automatic test_serial_ack;
        logic [3:0] d;
        d     = 4'b1010;
        start = 1'b1;
        delay = d;
        tick();
        start = 1'b0;
        delay = 4'($urandom);
        for (int i = 0; i < FL; i++) begin
            checks++; if (x !== frame_bit(d, i)) begin errors++; $display("[TB] FAIL serial_x[%0d]: got %b expected %b", i, x, frame_bit(d, i)); end
            checks++; if ({busy, ready, ack, timeout} !== 4'b1000) begin errors++; $display("[TB] FAIL serial_status[%0d]: got %b expected 1000", i, {busy, ready, ack, timeout}); end
            tick();
        end
        for (int w = 0; w < 50; w++) begin
            checks++; if ({busy, ready, ack, timeout, x} !== 5'b10000) begin errors++; $display("[TB] FAIL wait_status[%0d]: got %b expected 10000", w, {busy, ready, ack, timeout, x}); end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if ({busy, ready, ack, timeout, x} !== 5'b10100) begin errors++; $display("[TB] FAIL ack_cycle: got %b expected 10100", {busy, ready, ack, timeout, x}); end
        tick();
        checks++; if ({busy, ready, ack, timeout, x} !== 5'b01000) begin errors++; $display("[TB] FAIL after_ack_idle: got %b expected 01000", {busy, ready, ack, timeout, x}); end
    endtask

    task automatic test_ignored_inputs;
        logic [3:0] d;
        d     = 4'b1010;
        start = 1'b1;
        delay = d;
        tick();
        for (int i = 0; i < FL; i++) begin
            checks++; if (x !== frame_bit(d, i)) begin errors++; $display("[TB] FAIL ignored_x[%0d]: got %b expected %b", i, x, frame_bit(d, i)); end
            checks++; if ({busy, ready, ack} !== 3'b100) begin errors++; $display("[TB] FAIL ignored_status[%0d]: got %b expected 100", i, {busy, ready, ack}); end
            if (i >= GAP && i < GAP + 4) begin
                start = 1'b1;
                done  = 1'b1;
                delay = 4'b0101;
            end else begin
                start = 1'b0;
                done  = 1'b0;
            end
            tick();
        end
        for (int w = 0; w < 3; w++) begin
            checks++; if ({busy, ready, ack, x} !== 4'b1000) begin errors++; $display("[TB] FAIL ignored_wait[%0d]: got %b expected 1000", w, {busy, ready, ack, x}); end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL ignored_ack: got %b expected 1", ack); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ignored_idle: got %b expected 1", ready); end
    endtask

    task automatic test_mid_reset;
        logic [3:0] d;
        d     = 4'($urandom);
        start = 1'b1;
        delay = d;
        tick();
        start = 1'b0;
        for (int i = 0; i <= GAP + 5; i++) begin
            checks++; if (x !== frame_bit(d, i)) begin errors++; $display("[TB] FAIL midrst_x[%0d]: got %b expected %b", i, x, frame_bit(d, i)); end
            if (i < GAP + 5) tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if ({busy, ready, ack, timeout, x} !== 5'b01000) begin errors++; $display("[TB] FAIL midrst_state: got %b expected 01000", {busy, ready, ack, timeout, x}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({busy, ready, x} !== 3'b010) begin errors++; $display("[TB] FAIL midrst_quiet[%0d]: got %b expected 010", k, {busy, ready, x}); end
        end
        d     = 4'b1111;
        start = 1'b1;
        delay = d;
        tick();
        start = 1'b0;
        for (int i = 0; i < FL; i++) begin
            checks++; if (x !== frame_bit(d, i)) begin errors++; $display("[TB] FAIL midrst_new_x[%0d]: got %b expected %b", i, x, frame_bit(d, i)); end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if ({busy, ready, ack} !== 3'b101) begin errors++; $display("[TB] FAIL midrst_ack: got %b expected 101", {busy, ready, ack}); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [3:0] d1, d2;
        d1    = 4'($urandom);
        d2    = 4'($urandom);
        start = 1'b1;
        delay = d1;
        tick();
        delay = d2;
        for (int i = 0; i < FL; i++) begin
            checks++; if (x !== frame_bit(d1, i)) begin errors++; $display("[TB] FAIL b2b_first_x[%0d]: got %b expected %b", i, x, frame_bit(d1, i)); end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if ({busy, ready, ack} !== 3'b101) begin errors++; $display("[TB] FAIL b2b_ack: got %b expected 101", {busy, ready, ack}); end
        tick();
        checks++; if ({busy, ready, ack, x} !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 0100", {busy, ready, ack, x}); end
        tick();
        for (int i = 0; i < FL; i++) begin
            checks++; if ({busy, x} !== {1'b1, frame_bit(d2, i)}) begin errors++; $display("[TB] FAIL b2b_second[%0d]: got %b expected %b", i, {busy, x}, {1'b1, frame_bit(d2, i)}); end
            tick();
        end
        start = 1'b0;
        done  = 1'b1;
        tick();
        done  = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_ack: got %b expected 1", ack); end
        tick();
    endtask

    task automatic test_random;
        logic [3:0] d;
        int         limit;
        for (int n = 0; n < 24; n++) begin
            d     = 4'($urandom);
            start = 1'b1;
            delay = d;
            tick();
            for (int i = 0; i < FL; i++) begin
                checks++; if (x !== frame_bit(d, i)) begin errors++; $display("[TB] FAIL rnd%0d_x[%0d]: got %b expected %b", n, i, x, frame_bit(d, i)); end
                checks++; if ({busy, ready, ack, timeout} !== 4'b1000) begin errors++; $display("[TB] FAIL rnd%0d_status[%0d]: got %b expected 1000", n, i, {busy, ready, ack, timeout}); end
                start = 1'($urandom_range(0, 1));
                done  = 1'($urandom_range(0, 1));
                delay = 4'($urandom);
                tick();
            end
            done  = 1'b0;
            limit = int'($urandom_range(0, 6));
            for (int w = 0; w <= limit; w++) begin
                checks++; if ({busy, ready, ack, timeout, x} !== 5'b10000) begin errors++; $display("[TB] FAIL rnd%0d_wait[%0d]: got %b expected 10000", n, w, {busy, ready, ack, timeout, x}); end
                start = 1'($urandom_range(0, 1));
                done  = (w == limit);
                tick();
            end
            done  = 1'($urandom_range(0, 1));
            checks++; if ({busy, ready, ack, timeout, x} !== 5'b10100) begin errors++; $display("[TB] FAIL rnd%0d_ack: got %b expected 10100", n, {busy, ready, ack, timeout, x}); end
            start = 1'b0;
            tick();
            done  = 1'b1;
            checks++; if ({busy, ready, ack, x} !== 4'b0100) begin errors++; $display("[TB] FAIL rnd%0d_idle: got %b expected 0100", n, {busy, ready, ack, x}); end
            tick();
            done  = 1'b0;
            checks++; if ({busy, ready, ack, x} !== 4'b0100) begin errors++; $display("[TB] FAIL rnd%0d_idle_done: got %b expected 0100", n, {busy, ready, ack, x}); end
        end
    endtask

`ifdef REVIEW2015_TX_TIMEOUT_EN
    task automatic test_timeout;
        reset_n = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int run = 0; run < 2; run++) begin
            start = 1'b1;
            delay = 4'($urandom);
            tick();
            start = 1'b0;
            for (int i = 0; i < FL; i++) tick();
            for (int w = 0; w < TMO; w++) begin
                checks++; if ({t_busy, t_ack, t_timeout} !== 3'b100) begin errors++; $display("[TB] FAIL tmo%0d_wait[%0d]: got %b expected 100", run, w, {t_busy, t_ack, t_timeout}); end
                done = (run == 1) && (w == TMO - 1);
                tick();
            end
            done = 1'b0;
            if (run == 0) begin
                checks++; if ({t_ready, t_ack, t_timeout} !== 3'b101) begin errors++; $display("[TB] FAIL tmo_expire: got %b expected 101", {t_ready, t_ack, t_timeout}); end
            end else begin
                checks++; if ({t_ready, t_ack, t_timeout} !== 3'b010) begin errors++; $display("[TB] FAIL tmo_done_wins: got %b expected 010", {t_ready, t_ack, t_timeout}); end
            end
            tick();
            checks++; if ({t_ready, t_ack, t_timeout} !== 3'b100) begin errors++; $display("[TB] FAIL tmo%0d_after: got %b expected 100", run, {t_ready, t_ack, t_timeout}); end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        delay   = 4'd0;
        test_reset();
        test_serial_ack();
        test_ignored_inputs();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef REVIEW2015_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
